// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants and types for the UART transmit path.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'h1B;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD_ESC   = 3'd1,
        CMD_BYTE  = 3'd2,
        DATA      = 3'd3,
        DATA_ESC2 = 3'd4
    } tx_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Shares the UART TX between escaped commands and atomic data frames.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter logic [7:0] ESC_CHAR      = ESC_CHAR_DEFAULT,
    parameter int         CMD_BURST_MAX = 4
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       CMD_VALID_I,
    input  logic [7:0] CMD_I,
    output logic       CMD_READY_O,
    output logic       CMD_DROP_O,
    input  logic       DATA_VALID_I,
    input  logic [7:0] DATA_I,
    input  logic       DATA_LAST_I,
    output logic       DATA_READY_O,
    input  logic       TX_READY_I,
    output logic       WRITE_O,
    output logic [7:0] DATA_O,
    output logic       BUSY_O
);

    localparam int                  c_STREAK_W  = $clog2(CMD_BURST_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_BURST_MAX = c_STREAK_W'(CMD_BURST_MAX);

    tx_arb_state_t           r_state;
    tx_arb_state_t           w_state;
    logic [7:0]              r_cmd;
    logic [7:0]              w_cmd;
    logic [c_STREAK_W-1:0]   r_streak;
    logic [c_STREAK_W-1:0]   w_streak;
    logic                    w_cmd_win;
    logic                    w_cmd_ready;
    logic                    w_cmd_drop;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state  <= IDLE;
            r_cmd    <= 8'h00;
            r_streak <= '0;
        end else begin
            r_state  <= w_state;
            r_cmd    <= w_cmd;
            r_streak <= w_streak;
        end
    end

    assign w_cmd_win = CMD_VALID_I && (!DATA_VALID_I || (r_streak < c_BURST_MAX));

    always_comb begin
        w_state      = r_state;
        w_cmd        = r_cmd;
        w_streak     = r_streak;
        w_cmd_ready  = 1'b0;
        w_cmd_drop   = 1'b0;
        WRITE_O      = 1'b0;
        DATA_O       = 8'h00;
        DATA_READY_O = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_win) begin
                    w_cmd_ready = 1'b1;
                    // An ESC command cannot be framed unambiguously, so it is acknowledged and dropped.
                    if (CMD_I == ESC_CHAR) begin
                        w_cmd_drop = 1'b1;
                    end else begin
                        w_cmd   = CMD_I;
                        w_state = CMD_ESC;
                    end
                end else if (DATA_VALID_I) begin
                    w_state = DATA;
                end
            end
            CMD_ESC: begin
                WRITE_O = 1'b1;
                DATA_O  = ESC_CHAR;
                if (TX_READY_I) begin
                    w_state = CMD_BYTE;
                end
            end
            CMD_BYTE: begin
                WRITE_O = 1'b1;
                DATA_O  = r_cmd;
                if (TX_READY_I) begin
                    w_state = IDLE;
                    if (r_streak != c_BURST_MAX) begin
                        w_streak = r_streak + c_STREAK_W'(1);
                    end
                end
            end
            DATA: begin
                WRITE_O = DATA_VALID_I;
                DATA_O  = DATA_I;
                if (DATA_VALID_I && TX_READY_I) begin
                    if (DATA_I == ESC_CHAR) begin
                        w_state = DATA_ESC2;
                    end else begin
                        DATA_READY_O = 1'b1;
                        if (DATA_LAST_I) begin
                            w_state  = IDLE;
                            w_streak = '0;
                        end
                    end
                end
            end
            DATA_ESC2: begin
                WRITE_O      = 1'b1;
                DATA_O       = ESC_CHAR;
                DATA_READY_O = TX_READY_I;
                if (TX_READY_I) begin
                    if (DATA_LAST_I) begin
                        w_state  = IDLE;
                        w_streak = '0;
                    end else begin
                        w_state = DATA;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // The IDLE handshake depends on live inputs, so hold it off while reset is asserted.
    assign CMD_READY_O = w_cmd_ready & RST_NI;
    assign CMD_DROP_O  = w_cmd_drop & RST_NI;
    assign BUSY_O      = (r_state != IDLE);

endmodule
`default_nettype wire
